// File: rtl/dmem_port_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module   : dmem_port_arbiter_if                                          |
// | Purpose  : Bundles the core request/response channel, the external       |
// |            master request/response channel and the data-SRAM port used   |
// |            by dmem_port_arbiter.                                         |
// | Modports : slave  - the arbiter (accepts requests, drives the SRAM)      |
// |            master - requesters plus the SRAM model / surrounding fabric  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dmem_port_arbiter_if;
  // Core data port
  logic        io_core_req_valid;
  logic        io_core_req_ready;
  logic [31:0] io_core_req_addr;
  logic        io_core_req_wen;
  logic [3:0]  io_core_req_mask;
  logic [31:0] io_core_req_wdata;
  logic        io_core_resp_valid;
  logic [31:0] io_core_resp_rdata;
  // External bus master (debug/DMA)
  logic        io_ext_req_valid;
  logic        io_ext_req_ready;
  logic [31:0] io_ext_req_addr;
  logic        io_ext_req_wen;
  logic [3:0]  io_ext_req_mask;
  logic [31:0] io_ext_req_wdata;
  logic        io_ext_resp_valid;
  logic [31:0] io_ext_resp_rdata;
  // Shared synchronous SRAM port
  logic        io_mem_en;
  logic        io_mem_wen;
  logic [31:0] io_mem_addr;
  logic [3:0]  io_mem_mask;
  logic [31:0] io_mem_wdata;
  logic [31:0] io_mem_rdata;

  modport slave (
    input  io_core_req_valid, io_core_req_addr, io_core_req_wen,
           io_core_req_mask, io_core_req_wdata,
    output io_core_req_ready, io_core_resp_valid, io_core_resp_rdata,
    input  io_ext_req_valid, io_ext_req_addr, io_ext_req_wen,
           io_ext_req_mask, io_ext_req_wdata,
    output io_ext_req_ready, io_ext_resp_valid, io_ext_resp_rdata,
    output io_mem_en, io_mem_wen, io_mem_addr, io_mem_mask, io_mem_wdata,
    input  io_mem_rdata
  );

  modport master (
    output io_core_req_valid, io_core_req_addr, io_core_req_wen,
           io_core_req_mask, io_core_req_wdata,
    input  io_core_req_ready, io_core_resp_valid, io_core_resp_rdata,
    output io_ext_req_valid, io_ext_req_addr, io_ext_req_wen,
           io_ext_req_mask, io_ext_req_wdata,
    input  io_ext_req_ready, io_ext_resp_valid, io_ext_resp_rdata,
    input  io_mem_en, io_mem_wen, io_mem_addr, io_mem_mask, io_mem_wdata,
    output io_mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : dmem_port_arbiter                                             |
// | Purpose  : Shares one synchronous data-SRAM port between the core and an |
// |            external master. One combinational grant per cycle; each      |
// |            response returns to its issuer exactly one cycle later.       |
// | Ports    : clk, rst (sync, active high)                                  |
// |            bus (dmem_port_arbiter_if.slave): core req/resp, ext req/resp,|
// |            SRAM strobes/address/mask/data and read data                  |
// | Params   : STARVE_LIMIT (1..15) lost cycles before ext overrides core    |
// | Macros   : ARB_ROUND_ROBIN_EN - round-robin tie-break instead of fixed   |
// |            core priority with starvation override                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
);

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_EXT  = 1'b1;

  logic        grant_core;
  logic        grant_ext;
  logic        grant_any;
  logic        sel_wen;
  logic [31:0] sel_addr;
  logic [3:0]  sel_mask;
  logic [31:0] sel_wdata;

  logic        resp_pending;
  logic        resp_owner;
  logic        resp_is_read;
  logic        resp_live;
  logic [31:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;
`else
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  logic [3:0]  starve_cnt;
`endif

  // Grant: only a tie needs a decision; a lone valid requester always wins.
  always_comb begin
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    if (!rst) begin
      if (bus.io_core_req_valid && bus.io_ext_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_ext = (last_grant == OWNER_CORE);
`else
        grant_ext = (starve_cnt == c_starve_limit);
`endif
        grant_core = !grant_ext;
      end else begin
        grant_core = bus.io_core_req_valid;
        grant_ext  = bus.io_ext_req_valid;
      end
    end
  end

  assign grant_any = grant_core | grant_ext;

  // Payload mux; everything is zero when nobody is granted.
  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = 32'd0;
    sel_mask  = 4'd0;
    sel_wdata = 32'd0;
    if (grant_core) begin
      sel_wen   = bus.io_core_req_wen;
      sel_addr  = bus.io_core_req_addr;
      sel_mask  = bus.io_core_req_mask;
      sel_wdata = bus.io_core_req_wdata;
    end else if (grant_ext) begin
      sel_wen   = bus.io_ext_req_wen;
      sel_addr  = bus.io_ext_req_addr;
      sel_mask  = bus.io_ext_req_mask;
      sel_wdata = bus.io_ext_req_wdata;
    end
  end

  assign bus.io_core_req_ready = grant_core;
  assign bus.io_ext_req_ready  = grant_ext;
  assign bus.io_mem_en         = grant_any;
  assign bus.io_mem_wen        = sel_wen;
  assign bus.io_mem_addr       = sel_addr;
  assign bus.io_mem_mask       = sel_wen ? sel_mask : 4'd0;
  assign bus.io_mem_wdata      = sel_wdata;

  // Response tracking: remembers who owns the SRAM result due next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pending <= 1'b0;
      resp_owner   <= OWNER_CORE;
      resp_is_read <= 1'b0;
    end else begin
      resp_pending <= grant_any;
      if (grant_any) begin
        resp_owner   <= grant_ext ? OWNER_EXT : OWNER_CORE;
        resp_is_read <= !sel_wen;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWNER_CORE;
    end else if (grant_any) begin
      last_grant <= grant_ext ? OWNER_EXT : OWNER_CORE;
    end
  end
`else
  // Counts consecutive cycles ext waited; saturates so the override holds
  // until ext is actually served or withdraws.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.io_ext_req_valid || grant_ext) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != c_starve_limit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Gating with rst drops a response that falls due in a reset cycle.
  assign resp_live = resp_pending && !rst;
  assign resp_data = resp_is_read ? bus.io_mem_rdata : 32'd0;

  assign bus.io_core_resp_valid = resp_live && (resp_owner == OWNER_CORE);
  assign bus.io_ext_resp_valid  = resp_live && (resp_owner == OWNER_EXT);
  assign bus.io_core_resp_rdata = bus.io_core_resp_valid ? resp_data : 32'd0;
  assign bus.io_ext_resp_rdata  = bus.io_ext_resp_valid  ? resp_data : 32'd0;

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares a single synchronous data-memory port between the core's data port and an external bus master (debug/DMA). Arbitrates one request per cycle, drives the memory strobes, and returns each response to the requester that issued it exactly one cycle later. Sits between the core's dmem interface and the data SRAM. The core side's `ready` low is what the core's control path turns into `ctl_stall`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive lost cycles after which the external master wins; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `io_core_req_valid`  in  1  core request present
- `io_core_req_ready`  out  1  core request accepted this cycle
- `io_core_req_addr`  in  32  byte address
- `io_core_req_wen`  in  1  1 = write, 0 = read
- `io_core_req_mask`  in  4  byte-lane write mask
- `io_core_req_wdata`  in  32  write data
- `io_core_resp_valid`  out  1  response for the core
- `io_core_resp_rdata`  out  32  read data, or 0 for writes
- `io_ext_req_valid`, `io_ext_req_ready`, `io_ext_req_addr`, `io_ext_req_wen`, `io_ext_req_mask`, `io_ext_req_wdata`, `io_ext_resp_valid`, `io_ext_resp_rdata`: same widths and meaning, external master
- `io_mem_en`  out  1  memory access this cycle
- `io_mem_wen`  out  1  write strobe
- `io_mem_addr`  out  32  address
- `io_mem_mask`  out  4  byte mask, forced to 0 on reads
- `io_mem_wdata`  out  32  write data
- `io_mem_rdata`  in  32  read data, valid the cycle after `io_mem_en` with `io_mem_wen`=0

## Operation
- Accept occurs when `valid & ready`. Requesters hold `valid` and payload stable until accepted.
- Grant is combinational. At most one `ready` is high per cycle, and `ready` is high only if the matching `valid` is high.
- Default priority: core wins when both requesters are valid.
- Starvation counter `starve_cnt` (4 bits):
  - Increments on each cycle that ext is valid and not granted, saturating at `STARVE_LIMIT`.
  - Clears on an ext grant or on a cycle with ext not valid.
  - When `starve_cnt == STARVE_LIMIT` and both requesters are valid, ext wins.
- The `io_mem_*` outputs mirror the granted request's payload in the same cycle. `io_mem_en` = any grant. With no grant, all `io_mem_*` outputs are 0.
- Response tracking registers:
  - `resp_owner` (core/ext) and `resp_pending` are set on every accept.
  - The next cycle the owner's `resp_valid` = 1.
  - `rdata` = `io_mem_rdata` for a read, or 0 for a write.
  - The non-owner's `resp_valid` = 0.
- Fully pipelined: back-to-back accepts are allowed. Throughput is 1 access/cycle total.

## Timing
- Latency: accept in cycle N leads to `resp_valid` in cycle N+1, exactly one cycle. There is no backpressure on responses.
- Reset (`rst`=1 at an edge):
  - `starve_cnt`=0, `resp_pending`=0, `resp_owner`=core, last-grant=core.
  - While `rst`=1: all `ready`, `resp_valid`, and `io_mem_*` outputs are 0. `resp_rdata` is 0.
- Reset mid-operation: a response due in the reset cycle is dropped. No `resp_valid` is asserted in the cycle after reset deasserts unless an accept happened while out of reset.
- Simultaneous events:
  - Both requesters valid with `starve_cnt` < limit: core wins and `starve_cnt` increments.
  - Both valid with `starve_cnt` == limit: ext wins and `starve_cnt` clears.
- A write followed by a read to the same address in the next cycle: ordering is preserved by the memory. The arbiter performs no forwarding.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Arbitration is round-robin. When both requesters are valid, the one not granted most recently wins.
  - The last-grant register updates on every accept.
  - `starve_cnt` and `STARVE_LIMIT` are unused; the parameter remains legal.
- `ARB_ROUND_ROBIN_EN` undefined: fixed core priority with the starvation override described in Operation.

## Test plan
- Single core read of addr 0x100 holding 0xDEADBEEF: `io_core_req_ready`=1 same cycle, `io_mem_en`=1, `io_mem_wen`=0, `io_mem_mask`=0. Next cycle `io_core_resp_valid`=1, rdata=0xDEADBEEF, `io_ext_resp_valid`=0.
- Ext write 0x12345678 to 0x200 with mask 0xF, then ext read of 0x200 the next cycle: write resp rdata=0; read resp returns 0x12345678 one cycle after its accept.
- Both requesters valid continuously, `STARVE_LIMIT`=4, macro undefined: grant sequence is core ×4, ext, core ×4, ext.
- Same stimulus with `ARB_ROUND_ROBIN_EN` defined: grants alternate ext, core, ext, … (the last-grant register resets to core, so ext gets the first tie). Each response is routed to the correct owner.
- Core read accepted, then `rst` asserted the next cycle: no `resp_valid` on either side during or after reset. Counters are 0. The first post-reset accept gets grant per reset priority.
- Idle bus (no valids): all `io_mem_*` outputs = 0, both `ready` = 0, `starve_cnt` stays 0.
